// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: opcodes, ALU codes, mux encodings and FSM states shared by the controller files
package multicycle_control_unit_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] ALU_ADD = 6'b011000;
    localparam logic [5:0] ALU_SUB = 6'b011001;
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP
    } state_t;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: memory handshake (master drives mem_req/mem_we/iord, slave drives mem_ready)
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;
    modport master (output mem_req, mem_we, iord, input mem_ready);
    modport slave (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit_output_decode.sv
// mcu_output_decode: state + opcode + mem_ready -> control vector, all zero while rst_n is low
module mcu_output_decode
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W            = 6,
    parameter int FUNCT_W         = 6,
    parameter int SHAMT_W         = 5,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  state_t             state,
    input  logic               rst_n,
    input  logic               mem_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [SHAMT_W-1:0] amount,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               pc_write,
    output logic               pc_write_eq,
    output logic               pc_write_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [FUNCT_W-1:0] alu_control,
    output logic [SHAMT_W-1:0] shift_contr,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal
);
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mdr_write   = 1'b0;
        pc_write    = 1'b0;
        pc_write_eq = 1'b0;
        pc_write_ne = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_REG;
        alu_control = FUNCT_W'(ALU_ADD);
        shift_contr = '0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: alu_src_b = SRC_B_IMM_SH;
            EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = funct;
                shift_contr = amount;
            end
            EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_IMM;
                alu_control = (op == OP_W'(OP_SUBI)) ? FUNCT_W'(ALU_SUB) : FUNCT_W'(ALU_ADD);
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            MEM_RD: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mdr_write = mem_ready;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            WB_I: reg_write = 1'b1;
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = FUNCT_W'(ALU_SUB);
                pc_src      = PC_SRC_ALUOUT;
                pc_write_eq = (op == OP_W'(OP_BEQ));
                pc_write_ne = (op == OP_W'(OP_BNE));
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
            end
            TRAP: begin
                illegal     = 1'b1;
                alu_control = (HALT_ON_ILLEGAL != 0) ? '0 : FUNCT_W'(ALU_ADD);
            end
            default: ;
        endcase
        if (!rst_n)
            {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_eq, pc_write_ne, pc_src,
             alu_src_a, alu_src_b, alu_control, shift_contr, reg_write, reg_dst, mem_to_reg, illegal} = '0;
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/execute/memory/write-back controller with memory handshake (mem), retire counter and illegal-opcode trap
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W            = 6,
    parameter int FUNCT_W         = 6,
    parameter int SHAMT_W         = 5,
    parameter int CNT_W           = 32,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OP_W-1:0]     i_op,
    input  logic [FUNCT_W-1:0]  i_funct,
    input  logic [SHAMT_W-1:0]  i_amount,
    multicycle_control_unit_if.master mem,
    output logic                o_ir_write,
    output logic                o_mdr_write,
    output logic                o_pc_write,
    output logic                o_pc_write_eq,
    output logic                o_pc_write_ne,
    output logic [1:0]          o_pc_src,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [FUNCT_W-1:0]  o_alu_control,
    output logic [SHAMT_W-1:0]  o_shift_contr,
    output logic                o_reg_write,
    output logic                o_reg_dst,
    output logic                o_mem_to_reg,
    output logic                o_illegal,
    output logic [CNT_W-1:0]    o_retired
);
    state_t state, state_nxt;
    logic   retire;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= FETCH;
            o_retired <= '0;
        end else begin
            state     <= state_nxt;
            o_retired <= o_retired + CNT_W'(retire);
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            FETCH: state_nxt = mem.mem_ready ? DECODE : FETCH;
            DECODE: state_nxt = (i_op == OP_W'(OP_R)) ? EXEC_R :
                                (i_op == OP_W'(OP_ADDI) || i_op == OP_W'(OP_SUBI)) ? EXEC_I :
                                (i_op == OP_W'(OP_LW) || i_op == OP_W'(OP_SW)) ? MEM_ADDR :
                                (i_op == OP_W'(OP_BEQ) || i_op == OP_W'(OP_BNE)) ? BRANCH :
                                (i_op == OP_W'(OP_J)) ? JUMP : TRAP;
            EXEC_R: state_nxt = WB_R;
            EXEC_I: state_nxt = WB_I;
            MEM_ADDR: state_nxt = (i_op == OP_W'(OP_LW)) ? MEM_RD : MEM_WR;
            MEM_RD: state_nxt = mem.mem_ready ? WB_MEM : MEM_RD;
            MEM_WR: begin
                retire    = mem.mem_ready;
                state_nxt = mem.mem_ready ? FETCH : MEM_WR;
            end
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: begin
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            TRAP: state_nxt = (HALT_ON_ILLEGAL != 0) ? TRAP : FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    mcu_output_decode #(
        .OP_W(OP_W), .FUNCT_W(FUNCT_W), .SHAMT_W(SHAMT_W), .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
    ) u_decode (
        .state(state),
        .rst_n(i_rst_n),
        .mem_ready(mem.mem_ready),
        .op(i_op),
        .funct(i_funct),
        .amount(i_amount),
        .mem_req(mem.mem_req),
        .mem_we(mem.mem_we),
        .iord(mem.iord),
        .ir_write(o_ir_write),
        .mdr_write(o_mdr_write),
        .pc_write(o_pc_write),
        .pc_write_eq(o_pc_write_eq),
        .pc_write_ne(o_pc_write_ne),
        .pc_src(o_pc_src),
        .alu_src_a(o_alu_src_a),
        .alu_src_b(o_alu_src_b),
        .alu_control(o_alu_control),
        .shift_contr(o_shift_contr),
        .reg_write(o_reg_write),
        .reg_dst(o_reg_dst),
        .mem_to_reg(o_mem_to_reg),
        .illegal(o_illegal)
    );
endmodule
